// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one 4-bit carry-chain slice reused across the operand
// one nibble per clock, with valid/ready handshakes on both sides.

module cc4 (
  input  logic       ci,
  input  logic [3:0] di,
  input  logic [3:0] s,
  output logic [3:0] co
);
  logic c;

  // Carry mux chain: propagate passes the incoming carry, otherwise generate from di.
  always_comb begin
    co = '0;
    c  = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      c     = s[i] ? c : di[i];
      co[i] = c;
    end
  end
endmodule

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  logic [3:0] prop;
  logic [3:0] co;

  assign prop = a ^ b;

  cc4 u_cc4 (
    .ci (c0),
    .di (a),
    .s  (prop),
    .co (co)
  );

  assign s  = prop ^ {co[2:0], c0};
  assign c4 = co[3];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  sum_sh_q, sum_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    s_nib;
  logic          c4;
  logic [W-1:0]  sum_shift;

  adder4 u_adder4 (
    .a  (a_sh_q[3:0]),
    .b  (b_sh_q[3:0]),
    .c0 (carry_q),
    .s  (s_nib),
    .c4 (c4)
  );

  // New nibbles enter at the top so nibble 0 ends up in bits [3:0] after the last RUN edge.
  if (NIBBLES == 1) begin : g_single
    assign sum_shift = s_nib;
  end else begin : g_multi
    assign sum_shift = {s_nib, sum_sh_q[W-1:4]};
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_shift;
        carry_d  = c4;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and table-driven checks of nibble_serial_adder at NIBBLES=8, plus a
// NIBBLES=1 instance exercised with a reference model and random backpressure.

module tb_nibble_serial_adder;
  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
  logic        in_valid_1, in_ready_1, cin_1, out_valid_1, out_ready_1, cout_1;
  logic [3:0]  a_1, b_1, sum_1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.NIBBLES(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_1),
    .in_ready  (in_ready_1),
    .a         (a_1),
    .b         (b_1),
    .cin       (cin_1),
    .out_valid (out_valid_1),
    .out_ready (out_ready_1),
    .sum       (sum_1),
    .cout      (cout_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // One full NIBBLES=8 transaction with out_ready held high; entered and left on a negedge.
  task automatic run8(input string name, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input logic [31:0] es, input logic ec);
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 8);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    @(negedge clk);
    check({name, "_ready_after"}, in_ready, 1);
    check({name, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    logic [32:0] ref33;
    logic [4:0]  ref5;
    logic [31:0] hs, hb;
    logic        hc;
    logic        seen;
    logic        r;
    int          lat;
    int          guard;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 1'b0};

    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0; out_ready_1 = 1'b0;

    // Reset asserted between edges takes effect immediately
    #7 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_n1_in_ready", in_ready_1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);
    check("post_rst_cout", cout, 0);

    for (int i = 0; i < 8; i++) begin
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
           vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Backpressure with in_valid pulsing: output must hold and nothing gets captured
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h8765_4321; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 32'h9999_999A);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      a = 32'h1111_1111; b = 32'h1111_1111; cin = 1'b0; in_valid = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_hold_sum", sum, 32'h9999_999A);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    check("bp_hs_sum_hold", sum, 32'h9999_999A);
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_no_capture", in_ready, 1);

    // Reset mid-RUN abandons the transaction
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrun_no_valid", seen, 0);
    run8("after_rst", 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0);

    // Random NIBBLES=8 against a 33-bit reference sum
    for (int i = 0; i < 20; i++) begin
      hb = $urandom; hs = $urandom; hc = 1'($urandom_range(0, 1));
      ref33 = {1'b0, hb} + {1'b0, hs} + {32'd0, hc};
      run8("rand8", hb, hs, hc, ref33[31:0], ref33[32]);
    end

    // NIBBLES=1 directed case
    @(negedge clk);
    check("n1_in_ready", in_ready_1, 1);
    a_1 = 4'hF; b_1 = 4'h1; cin_1 = 1'b1; in_valid_1 = 1'b1; out_ready_1 = 1'b0;
    @(negedge clk);
    in_valid_1 = 1'b0;
    check("n1_run_valid", out_valid_1, 0);
    @(negedge clk);
    check("n1_valid", out_valid_1, 1);
    check("n1_sum", sum_1, 4'h1);
    check("n1_cout", cout_1, 1);
    out_ready_1 = 1'b1;
    @(negedge clk);
    check("n1_hs_valid", out_valid_1, 0);
    out_ready_1 = 1'b0;

    // NIBBLES=1 random with random backpressure
    for (int k = 0; k < 1000; k++) begin
      check("n1r_in_ready", in_ready_1, 1);
      a_1 = 4'($urandom); b_1 = 4'($urandom); cin_1 = 1'($urandom_range(0, 1));
      ref5 = {1'b0, a_1} + {1'b0, b_1} + {4'd0, cin_1};
      in_valid_1 = 1'b1;
      out_ready_1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      in_valid_1 = 1'b0;
      a_1 = 4'($urandom); b_1 = 4'($urandom);
      lat = 0;
      while (!out_valid_1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("n1r_latency", lat, 1);
      guard = 0;
      r = 1'b0;
      while (!r && guard < 64) begin
        check("n1r_sum", sum_1, ref5[3:0]);
        check("n1r_cout", cout_1, ref5[4]);
        in_valid_1 = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        out_ready_1 = r;
        @(negedge clk);
        guard++;
      end
      in_valid_1 = 1'b0;
      check("n1r_hs_done", r, 1);
      check("n1r_valid_after", out_valid_1, 0);
      out_ready_1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
